// File: rtl/mux_scan.sv
// Registered N-channel, W-bit multiplexer with a manual-select mode and an
// auto-scan mode that steps through the channels on a dwell counter.
module mux_scan #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL_W  = 8
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic                      hold,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          chan,
    output logic                      chan_change
);

    localparam logic [1:0] ST_MANUAL = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_FROZEN = 2'd2;

    localparam int             SLOTS     = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

    logic [1:0]         state_reg;
    logic [1:0]         state_next;
    logic [DWELL_W-1:0] cnt_reg;
    logic [DWELL_W-1:0] cnt_next;
    logic [DWELL_W-1:0] cnt_base;
    logic [SEL_W-1:0]   chan_next;
    logic [SEL_W-1:0]   chan_inc;
    logic               sel_ok;

    // Unused select codes read as zero so the output mux never indexes
    // outside the array, even though chan never reaches those codes.
    logic [WIDTH-1:0] slot [SLOTS];

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < CHANNELS) begin : g_live
                assign slot[gi] = data_in[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign slot[gi] = '0;
            end
        end
    endgenerate

    assign sel_ok   = (int'(sel) < CHANNELS);
    assign chan_inc = (chan == LAST_CHAN) ? '0 : chan + 1'b1;

    always_comb begin
        state_next = ST_MANUAL;
        if (mode) begin
            state_next = hold ? ST_FROZEN : ST_SCAN;
        end
    end

    // The counter restarts from zero whenever scanning begins out of manual,
    // so the starting channel gets its full dwell period.
    assign cnt_base = (state_reg == ST_MANUAL) ? '0 : cnt_reg;

    always_comb begin
        chan_next = chan;
        cnt_next  = cnt_reg;
        case (state_next)
            ST_SCAN: begin
                if (cnt_base == dwell) begin
                    cnt_next  = '0;
                    chan_next = chan_inc;
                end else begin
                    cnt_next  = cnt_base + 1'b1;
                end
            end
            ST_FROZEN: begin
                chan_next = chan;
                cnt_next  = cnt_reg;
            end
            default: begin
                cnt_next = '0;
                if (sel_ok) begin
                    chan_next = sel;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_MANUAL;
            cnt_reg     <= '0;
            chan        <= '0;
            data_out    <= '0;
            chan_change <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            chan        <= chan_next;
            data_out    <= slot[chan_next];
            chan_change <= (chan_next != chan);
        end
    end

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: two instances (4 and 3 channels) checked every cycle
// against a behavioural model, plus directed literal expectations.
module tb_mux_scan;

    logic        clock;
    logic        resetn;

    logic [15:0] d4;
    logic [1:0]  sel4;
    logic        mode4;
    logic [7:0]  dwell4;
    logic        hold4;
    logic [3:0]  out4;
    logic [1:0]  chan4;
    logic        chg4;

    logic [11:0] d3;
    logic [1:0]  sel3;
    logic        mode3;
    logic [3:0]  dwell3;
    logic        hold3;
    logic [3:0]  out3;
    logic [1:0]  chan3;
    logic        chg3;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    int m_chan [2];
    int m_cnt  [2];
    int m_out  [2];
    int m_chg  [2];

    mux_scan #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL_W(8)) u4 (
        .clock(clock), .resetn(resetn), .data_in(d4), .sel(sel4), .mode(mode4),
        .dwell(dwell4), .hold(hold4), .data_out(out4), .chan(chan4), .chan_change(chg4)
    );

    mux_scan #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL_W(4)) u3 (
        .clock(clock), .resetn(resetn), .data_in(d3), .sel(sel3), .mode(mode3),
        .dwell(dwell3), .hold(hold3), .data_out(out3), .chan(chan3), .chan_change(chg3)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model: one edge of the multiplexer from the behavioural rules.
    task automatic mstep(input int k, input int din, input int sel, input bit mode,
                         input int dwell, input bit hold, input int nch, input int dwbits);
        int nc;
        int ncnt;
        nc   = m_chan[k];
        ncnt = m_cnt[k];
        if (!mode) begin
            if (sel < nch) nc = sel;
            ncnt = 0;
        end else if (!hold) begin
            if (m_cnt[k] == dwell) begin
                nc   = (m_chan[k] + 1) % nch;
                ncnt = 0;
            end else begin
                ncnt = (m_cnt[k] + 1) % (1 << dwbits);
            end
        end
        m_chg[k]  = (nc != m_chan[k]) ? 1 : 0;
        m_chan[k] = nc;
        m_cnt[k]  = ncnt;
        m_out[k]  = (din >> (nc * 4)) & 15;
    endtask

    always @(negedge resetn) begin
        for (int k = 0; k < 2; k++) begin
            m_chan[k] = 0; m_cnt[k] = 0; m_out[k] = 0; m_chg[k] = 0;
        end
    end

    always @(posedge clock) begin
        if (resetn) begin
            mstep(0, 32'(d4), 32'(sel4), mode4, 32'(dwell4), hold4, 4, 8);
            mstep(1, 32'(d3), 32'(sel3), mode3, 32'(dwell3), hold3, 3, 4);
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("u4_data_out", 32'(out4), 32'(m_out[0]));
            chk("u4_chan", 32'(chan4), 32'(m_chan[0]));
            chk("u4_chan_change", 32'(chg4), 32'(m_chg[0]));
            chk("u3_data_out", 32'(out3), 32'(m_out[1]));
            chk("u3_chan", 32'(chan3), 32'(m_chan[1]));
            chk("u3_chan_change", 32'(chg3), 32'(m_chg[1]));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int exp_chan [13] = '{3, 3, 3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
    int exp_chg  [13] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int chd      [4]  = '{5, 10, 2, 13};

    initial begin
        resetn = 1;
        d4 = '0; sel4 = '0; mode4 = 0; dwell4 = '0; hold4 = 0;
        d3 = '0; sel3 = '0; mode3 = 0; dwell3 = '0; hold3 = 0;

        // Reset pulse mid-cycle, outputs clear without a clock edge
        #3 resetn = 0;
        #1;
        chk("rst_data_out", 32'(out4), 32'h0);
        chk("rst_chan", 32'(chan4), 32'h0);
        chk("rst_chan_change", 32'(chg4), 32'h0);
        d4 = 16'hD2A5; sel4 = 2'd2;
        @(negedge clock);
        resetn = 1;
        cmp_en = 1;
        tick();
        chk("sel2_data_out", 32'(out4), 32'h2);
        chk("sel2_chan", 32'(chan4), 32'd2);
        chk("sel2_chan_change", 32'(chg4), 32'd1);
        tick();
        chk("sel2_pulse_end", 32'(chg4), 32'd0);

        // Scan with wrap, dwell=2, starting from channel 3
        @(negedge clock);
        sel4 = 2'd3;
        tick();
        chk("wrap_chan_0", 32'(chan4), 32'(exp_chan[0]));
        chk("wrap_chg_0", 32'(chg4), 32'(exp_chg[0]));
        @(negedge clock);
        mode4 = 1; dwell4 = 8'd2;
        for (int i = 1; i < 13; i++) begin
            tick();
            chk("wrap_chan", 32'(chan4), 32'(exp_chan[i]));
            chk("wrap_chg", 32'(chg4), 32'(exp_chg[i]));
            chk("wrap_data", 32'(out4), 32'(chd[exp_chan[i]]));
        end

        // Hold with dwell=0; frozen channel's data changes 5 -> A
        @(negedge clock);
        mode4 = 0; sel4 = 2'd0; d4 = 16'h0050;
        tick();
        chk("hold_pre_chan", 32'(chan4), 32'd0);
        @(negedge clock);
        mode4 = 1; dwell4 = 8'd0; hold4 = 0;
        tick();
        chk("hold_adv_chan", 32'(chan4), 32'd1);
        chk("hold_adv_data", 32'(out4), 32'h5);
        @(negedge clock);
        hold4 = 1;
        tick();
        chk("hold_f1_chan", 32'(chan4), 32'd1);
        chk("hold_f1_data", 32'(out4), 32'h5);
        chk("hold_f1_chg", 32'(chg4), 32'd0);
        @(negedge clock);
        d4 = 16'h00A0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_fn_chan", 32'(chan4), 32'd1);
            chk("hold_fn_data", 32'(out4), 32'hA);
            chk("hold_fn_chg", 32'(chg4), 32'd0);
        end
        @(negedge clock);
        hold4 = 0;
        tick();
        chk("hold_release_chan", 32'(chan4), 32'd2);
        chk("hold_release_chg", 32'(chg4), 32'd1);

        // Mode switch mid-count, then return to scan holds chan 3 for dwell+1
        @(negedge clock);
        mode4 = 0; sel4 = 2'd1; d4 = 16'hD2A5;
        tick();
        @(negedge clock);
        mode4 = 1; dwell4 = 8'd5;
        tick();
        tick();
        chk("ms_mid_chan", 32'(chan4), 32'd1);
        @(negedge clock);
        mode4 = 0; sel4 = 2'd3;
        tick();
        chk("ms_exit_chan", 32'(chan4), 32'd3);
        chk("ms_exit_chg", 32'(chg4), 32'd1);
        chk("ms_exit_data", 32'(out4), 32'hD);
        @(negedge clock);
        mode4 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ms_dwell_chan", 32'(chan4), 32'd3);
        end
        tick();
        chk("ms_adv_chan", 32'(chan4), 32'd0);
        chk("ms_adv_chg", 32'(chg4), 32'd1);

        // Reset mid-scan at channel 2
        for (int i = 0; i < 40 && chan4 !== 2'd2; i++) tick();
        chk("wait_chan2", 32'(chan4), 32'd2);
        #2 resetn = 0;
        #1;
        chk("mrst_chan", 32'(chan4), 32'd0);
        chk("mrst_data", 32'(out4), 32'd0);
        chk("mrst_chg", 32'(chg4), 32'd0);
        @(negedge clock);
        resetn = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mrst_scan_chan", 32'(chan4), 32'd0);
        end
        tick();
        chk("mrst_adv_chan", 32'(chan4), 32'd1);

        // Out-of-range select on the 3-channel instance
        @(negedge clock);
        mode3 = 0; sel3 = 2'd1; d3 = 12'h3C5;
        tick();
        chk("oor_pre_chan", 32'(chan3), 32'd1);
        @(negedge clock);
        sel3 = 2'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("oor_chan", 32'(chan3), 32'd1);
            chk("oor_data", 32'(out3), 32'hC);
            chk("oor_chg", 32'(chg3), 32'd0);
        end

        // Randomized traffic on both instances, with occasional async resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            mode4 = ($urandom_range(9) != 0);
            hold4 = ($urandom_range(5) == 0);
            if ($urandom_range(15) == 0) dwell4 = 8'($urandom_range(6));
            sel4 = 2'($urandom);
            d4 = 16'($urandom);
            mode3 = ($urandom_range(9) != 0);
            hold3 = ($urandom_range(5) == 0);
            if ($urandom_range(15) == 0) dwell3 = 4'($urandom);
            sel3 = 2'($urandom);
            d3 = 12'($urandom);
            if ($urandom_range(199) == 0) begin
                #2 resetn = 0;
                @(negedge clock);
                resetn = 1;
            end
        end

        @(negedge clock);
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
